grid_server: RTL and testbench
==============================

Name: grid_server

Overview:
- Responder side of the grid-lookup interface: owns the level map and answers cell-type queries from the player updater (client 0) and the raycaster/renderer (client 1).
- Each client presents grid coordinates and a request, then receives a 3-bit cell code with a one-cycle acknowledge.
- A write port lets game logic (doors, pickups) change cells at run time.

Parameters:
- GRID_W, 40, number of valid columns (x in 0..GRID_W-1; port is 6 bits)
- GRID_H, 30, number of valid rows (y in 0..GRID_H-1; port is 5 bits)
- WALL_CODE, 3'b001, cell code returned for out-of-range coordinates

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- c0_req  in  1  client 0 (player updater) request, level, held until c0_ack
- c0_grid_x  in  6  client 0 column
- c0_grid_y  in  5  client 0 row
- c0_ack  out  1  one-cycle pulse, c0_cell valid
- c0_cell  out  3  client 0 cell code; holds its value until the next c0_ack
- c1_req  in  1  client 1 (renderer) request
- c1_grid_x  in  6  client 1 column
- c1_grid_y  in  5  client 1 row
- c1_ack  out  1  one-cycle pulse
- c1_cell  out  3  client 1 cell code, held
- wr_en  in  1  write strobe, one cell per cycle
- wr_x  in  6  write column
- wr_y  in  5  write row
- wr_cell  in  3  code to store
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Storage: 2048 x 3-bit array, address {y,x} (11 bits). Contents are not reset; initial contents come from the map init file.
- Reset: state IDLE; c0_ack=c1_ack=0; c0_cell=c1_cell=0; busy=0; rr pointer=0 (client 0 favoured).
- FSM:
  - IDLE: if any req is high, grant and go to READ; otherwise stay.
    - Grant rules: only one req high → grant that client. Both high → grant the client the rr pointer names, then flip the pointer.
    - On grant, latch the granted coordinates and the grant id.
  - READ: synchronous memory read of the latched address → RESP.
  - RESP: register the cell into cN_cell and pulse cN_ack for the granted client only → IDLE.
- Latency: req sampled in IDLE at edge n → ack high during cycle n+2. Throughput is one lookup per 3 cycles.
- Client rule: req must drop the cycle after ack. A req still high when the FSM is back in IDLE counts as a new request.
- Out of range (x>=GRID_W or y>=GRID_H): no memory read; returns WALL_CODE with identical timing.
- Writes: accepted in any state, committed at the clock edge. Out-of-range writes are ignored.
  - A read issued in the same cycle as a write to the same address returns the old value (read-before-write).
- Coordinates changing while req is high and before the grant are harmless; they are sampled only at grant.
- Reset asserted mid-transaction: FSM aborts immediately to IDLE, no ack is produced, and the client must re-request.
- busy=1 in READ and RESP.

Optional Feature:
- Macro: GRID_BORDER_WALL_EN.
- Defined: any in-range cell with x==0, x==GRID_W-1, y==0 or y==GRID_H-1 reads as WALL_CODE regardless of stored data, and writes to border cells are ignored.
- Undefined: border cells behave like any other cell.

Decomposition:
- Shared package/include:
  - cell-code constants: EMPTY=3'b000, WALL=3'b001, DOOR=3'b010, PICKUP=3'b011
  - GRID_W/GRID_H defaults
  - grid coordinate widths (6/5)
- One sub-module: grid_ram, an 11-bit-address x 3-bit synchronous read/write array with read-before-write behaviour and the init file.

Test Plan:
- Map cell (5,7)=DOOR; c0_req with x=5,y=7 at cycle 0 → c0_ack=1 exactly at cycle 2, c0_cell=3'b010, c1_ack stays 0.
- c0_req and c1_req rise together, both held and re-asserted → grants alternate c0, c1, c0; each ack 3 cycles apart; c1_cell correct for its own coordinates.
- c1_req with x=45,y=3 → c1_ack at cycle 2, c1_cell=3'b001, no RAM read enable observed.
- wr_en cell (10,10)=PICKUP in the same cycle c0's READ targets (10,10) → c0_cell=old value; next lookup returns 3'b011.
- Reset pulled low during READ → c0_ack never pulses, busy=0 and state IDLE immediately; after release, a new req completes normally.
- With GRID_BORDER_WALL_EN, (0,12) stored EMPTY → returns 3'b001; without the macro → returns 3'b000.

Source files
------------

// File: rtl/grid_server_pkg.sv
// Shared definitions for the grid lookup server: cell codes, grid geometry,
// FSM state and client identifiers.
package grid_server_pkg;

  localparam int GRID_X_W   = 6;
  localparam int GRID_Y_W   = 5;
  localparam int ADDR_W     = GRID_X_W + GRID_Y_W;
  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;

  typedef logic [2:0]          cell_t;
  typedef logic [GRID_X_W-1:0] grid_x_t;
  typedef logic [GRID_Y_W-1:0] grid_y_t;
  typedef logic [ADDR_W-1:0]   grid_addr_t;

  localparam cell_t CELL_EMPTY  = 3'b000;
  localparam cell_t CELL_WALL   = 3'b001;
  localparam cell_t CELL_DOOR   = 3'b010;
  localparam cell_t CELL_PICKUP = 3'b011;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_RESP} state_e;
  typedef enum logic       {CLIENT0, CLIENT1}          client_e;

  function automatic grid_addr_t grid_addr(input grid_x_t x, input grid_y_t y);
    return {y, x};
  endfunction

endpackage

// File: rtl/grid_server_if.sv
// Grid-lookup bus: two query clients plus the game-logic write port.
// master = clients / game logic, slave = grid_server.
interface grid_server_if;
  import grid_server_pkg::*;

  logic    c0_req;
  grid_x_t c0_grid_x;
  grid_y_t c0_grid_y;
  logic    c0_ack;
  cell_t   c0_cell;

  logic    c1_req;
  grid_x_t c1_grid_x;
  grid_y_t c1_grid_y;
  logic    c1_ack;
  cell_t   c1_cell;

  logic    wr_en;
  grid_x_t wr_x;
  grid_y_t wr_y;
  cell_t   wr_cell;

  logic    busy;

  modport master (
    output c0_req, c0_grid_x, c0_grid_y, c1_req, c1_grid_x, c1_grid_y,
           wr_en, wr_x, wr_y, wr_cell,
    input  c0_ack, c0_cell, c1_ack, c1_cell, busy
  );

  modport slave (
    input  c0_req, c0_grid_x, c0_grid_y, c1_req, c1_grid_x, c1_grid_y,
           wr_en, wr_x, wr_y, wr_cell,
    output c0_ack, c0_cell, c1_ack, c1_cell, busy
  );
endinterface

// File: rtl/grid_ram.sv
// 2048 x 3-bit level map with one write port and one synchronous read port;
// a read and a write to the same address in one cycle returns the old value.
module grid_ram
  import grid_server_pkg::*;
(
  input  logic       clock,
  input  logic       we,
  input  grid_addr_t waddr,
  input  cell_t      wdata,
  input  logic       re,
  input  grid_addr_t raddr,
  output cell_t      rdata
);

  cell_t mem [0:(1<<ADDR_W)-1];
  cell_t rdata_q;

  // NOTE: the array is deliberately left out of reset so it maps onto block RAM;
  // non-blocking writes mean the read below always sees the pre-edge contents.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q    <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/grid_server.sv
// Grid lookup responder: round-robin arbitration between two clients, a
// three-state IDLE/READ/RESP lookup and a run-time write port.
// Optional macro GRID_BORDER_WALL_EN forces border cells to read as walls and makes them read-only.
module grid_server
  import grid_server_pkg::*;
#(
  parameter int    GRID_W    = GRID_W_DEF,
  parameter int    GRID_H    = GRID_H_DEF,
  parameter cell_t WALL_CODE = CELL_WALL
) (
  input  logic          clock,
  input  logic          reset,
  grid_server_if.slave  bus
);

  function automatic logic in_range(input grid_x_t x, input grid_y_t y);
    return (x < 6'(GRID_W)) && (y < 5'(GRID_H));
  endfunction

`ifdef GRID_BORDER_WALL_EN
  function automatic logic on_border(input grid_x_t x, input grid_y_t y);
    return (x == '0) || (x == 6'(GRID_W - 1)) || (y == '0) || (y == 5'(GRID_H - 1));
  endfunction
  function automatic logic reads_wall(input grid_x_t x, input grid_y_t y);
    return !in_range(x, y) || on_border(x, y);
  endfunction
`else
  function automatic logic reads_wall(input grid_x_t x, input grid_y_t y);
    return !in_range(x, y);
  endfunction
`endif

  state_e     state_q, state_d;
  client_e    rr_q, rr_d, gnt_q, gnt_d;
  grid_addr_t addr_q, addr_d;
  logic       wall_q, wall_d;
  logic       c0_ack_q, c0_ack_d, c1_ack_q, c1_ack_d;
  cell_t      c0_cell_q, c0_cell_d, c1_cell_q, c1_cell_d;
  grid_x_t    gnt_x;
  grid_y_t    gnt_y;
  cell_t      resp_cell;
  cell_t      ram_rdata;
  logic       ram_re;
  logic       ram_we;

  // Reads of walls (out of range or border) never touch the array.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rr_q      <= CLIENT0;
      gnt_q     <= CLIENT0;
      addr_q    <= '0;
      wall_q    <= 1'b0;
      c0_ack_q  <= 1'b0;
      c1_ack_q  <= 1'b0;
      c0_cell_q <= '0;
      c1_cell_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wall_q    <= wall_d;
      c0_ack_q  <= c0_ack_d;
      c1_ack_q  <= c1_ack_d;
      c0_cell_q <= c0_cell_d;
      c1_cell_q <= c1_cell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.c0_req || bus.c1_req) state_d = ST_READ;
      ST_READ: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: every signal assigned here gets a default first, so no path infers a latch.
  always_comb begin
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wall_d    = wall_q;
    c0_ack_d  = 1'b0;
    c1_ack_d  = 1'b0;
    c0_cell_d = c0_cell_q;
    c1_cell_d = c1_cell_q;
    gnt_x     = '0;
    gnt_y     = '0;
    resp_cell = wall_q ? WALL_CODE : ram_rdata;
    ram_re    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.c0_req && bus.c1_req) begin
          gnt_d = rr_q;
          rr_d  = (rr_q == CLIENT0) ? CLIENT1 : CLIENT0;
        end else begin
          gnt_d = bus.c1_req ? CLIENT1 : CLIENT0;
        end
        gnt_x = (gnt_d == CLIENT1) ? bus.c1_grid_x : bus.c0_grid_x;
        gnt_y = (gnt_d == CLIENT1) ? bus.c1_grid_y : bus.c0_grid_y;
        if (bus.c0_req || bus.c1_req) begin
          addr_d = grid_addr(gnt_x, gnt_y);
          wall_d = reads_wall(gnt_x, gnt_y);
        end else begin
          gnt_d = gnt_q;
          rr_d  = rr_q;
        end
      end
      ST_READ: ram_re = !wall_q;
      ST_RESP: begin
        if (gnt_q == CLIENT1) begin
          c1_ack_d  = 1'b1;
          c1_cell_d = resp_cell;
        end else begin
          c0_ack_d  = 1'b1;
          c0_cell_d = resp_cell;
        end
      end
      default: ;
    endcase
  end

`ifdef GRID_BORDER_WALL_EN
  assign ram_we = bus.wr_en && in_range(bus.wr_x, bus.wr_y) && !on_border(bus.wr_x, bus.wr_y);
`else
  assign ram_we = bus.wr_en && in_range(bus.wr_x, bus.wr_y);
`endif

  grid_ram u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (grid_addr(bus.wr_x, bus.wr_y)),
    .wdata (bus.wr_cell),
    .re    (ram_re),
    .raddr (addr_q),
    .rdata (ram_rdata)
  );

  assign bus.c0_ack  = c0_ack_q;
  assign bus.c1_ack  = c1_ack_q;
  assign bus.c0_cell = c0_cell_q;
  assign bus.c1_cell = c1_cell_q;
  assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_grid_server.sv
// Randomized bench for grid_server against a 2-D map model of the level.
// Honours GRID_BORDER_WALL_EN the same way as the design.
module tb_grid_server;

  localparam int GW = 40;
  localparam int GH = 30;
  localparam logic [2:0] WALL = 3'b001;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [2:0] map [GH][GW];
  logic [2:0] last_cell [2];

  grid_server_if bus ();

  grid_server u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input int x, input int y);
    return (x < GW) && (y < GH);
  endfunction

  function automatic bit border(input int x, input int y);
`ifdef GRID_BORDER_WALL_EN
    return (x == 0) || (x == GW - 1) || (y == 0) || (y == GH - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit readable(input int x, input int y);
    return in_rng(x, y) && !border(x, y);
  endfunction

  function automatic logic [2:0] model_read(input int x, input int y);
    if (!readable(x, y)) return WALL;
    return map[y][x];
  endfunction

  task automatic model_write(input int x, input int y, input logic [2:0] c);
    if (readable(x, y)) map[y][x] = c;
  endtask

  task automatic write_cell(input int x, input int y, input logic [2:0] c);
    @(negedge clock);
    bus.wr_en = 1'b1; bus.wr_x = 6'(x); bus.wr_y = 5'(y); bus.wr_cell = c;
    @(posedge clock);
    model_write(x, y, c);
    #1 bus.wr_en = 1'b0;
  endtask

  task automatic set_req(input bit cl, input logic v, input int x, input int y);
    if (!cl) begin
      bus.c0_req = v; bus.c0_grid_x = 6'(x); bus.c0_grid_y = 5'(y);
    end else begin
      bus.c1_req = v; bus.c1_grid_x = 6'(x); bus.c1_grid_y = 5'(y);
    end
  endtask

  // One lookup from idle; optional write issued during the READ cycle.
  task automatic lookup(input bit cl, input int x, input int y, input bit do_wr,
                        input int wx, input int wy, input logic [2:0] wc, input string tag);
    logic [2:0] exp;
    @(negedge clock);
    set_req(cl, 1'b1, x, y);
    @(posedge clock);
    exp = model_read(x, y);
    #1;
    check({tag, "_busy_read"}, 32'(bus.busy), 32'(1));
    check({tag, "_ram_re"}, 32'(u_dut.ram_re), 32'(readable(x, y)));
    if (do_wr) begin
      bus.wr_en = 1'b1; bus.wr_x = 6'(wx); bus.wr_y = 5'(wy); bus.wr_cell = wc;
    end
    @(posedge clock);
    if (do_wr) model_write(wx, wy, wc);
    #1 bus.wr_en = 1'b0;
    check({tag, "_early_ack"}, 32'({bus.c0_ack, bus.c1_ack}), 32'(0));
    @(posedge clock); #1;
    check({tag, "_c0_ack"}, 32'(bus.c0_ack), 32'(!cl));
    check({tag, "_c1_ack"}, 32'(bus.c1_ack), 32'(cl));
    last_cell[cl] = exp;
    check({tag, "_cell"}, 32'(cl ? bus.c1_cell : bus.c0_cell), 32'(exp));
    check({tag, "_other_cell"}, 32'(cl ? bus.c0_cell : bus.c1_cell), 32'(last_cell[!cl]));
    check({tag, "_busy_idle"}, 32'(bus.busy), 32'(0));
    set_req(cl, 1'b0, x, y);
    @(posedge clock); #1;
    check({tag, "_ack_drop"}, 32'({bus.c0_ack, bus.c1_ack}), 32'(0));
  endtask

  initial begin
    reset = 1'b0;
    bus.c0_req = 1'b0; bus.c0_grid_x = '0; bus.c0_grid_y = '0;
    bus.c1_req = 1'b0; bus.c1_grid_x = '0; bus.c1_grid_y = '0;
    bus.wr_en  = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_cell = '0;
    last_cell[0] = '0; last_cell[1] = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_acks", 32'({bus.c0_ack, bus.c1_ack}), 32'(0));
    check("rst_cells", 32'({bus.c0_cell, bus.c1_cell}), 32'(0));
    reset = 1'b1;

    // Bring every in-range cell to a known random value through the write port.
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) begin
        map[y][x] = '0;
        write_cell(x, y, 3'($urandom_range(0, 7)));
      end

    write_cell(5, 7, 3'b010);
    lookup(0, 5, 7, 0, 0, 0, 3'b000, "door");

    lookup(1, 45, 3, 0, 0, 0, 3'b000, "oor_x");
    lookup(0, 12, 31, 0, 0, 0, 3'b000, "oor_y");

    write_cell(10, 10, 3'b000);
    lookup(0, 10, 10, 1, 10, 10, 3'b011, "rbw_old");
    lookup(0, 10, 10, 0, 0, 0, 3'b000, "rbw_new");
    check("rbw_value", 32'(bus.c0_cell), 32'(3'b011));

    write_cell(0, 12, 3'b000);
    lookup(0, 0, 12, 0, 0, 0, 3'b000, "border");
`ifdef GRID_BORDER_WALL_EN
    check("border_code", 32'(bus.c0_cell), 32'(3'b001));
`else
    check("border_code", 32'(bus.c0_cell), 32'(3'b000));
`endif

    for (int i = 0; i < 30; i++) begin
      int  x, y, wx, wy;
      bit  cl, do_wr;
      cl    = 1'($urandom_range(0, 1));
      x     = $urandom_range(0, 63);
      y     = $urandom_range(0, 31);
      do_wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        wx = x; wy = y;
      end else begin
        wx = $urandom_range(0, 63); wy = $urandom_range(0, 31);
      end
      lookup(cl, x, y, do_wr, wx, wy, 3'($urandom_range(0, 7)), "rand");
    end

    // Reset during READ aborts the lookup with no acknowledge.
    @(negedge clock);
    set_req(0, 1'b1, 3, 4);
    @(posedge clock); #1;
    check("abort_busy_read", 32'(bus.busy), 32'(1));
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_ack", 32'(bus.c0_ack), 32'(0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check("abort_no_ack", 32'({bus.c0_ack, bus.c1_ack}), 32'(0));
    end
    set_req(0, 1'b0, 3, 4);
    last_cell[0] = '0; last_cell[1] = '0;
    @(negedge clock);
    reset = 1'b1;
    lookup(0, 3, 4, 0, 0, 0, 3'b000, "after_abort");

    // Both clients held: pointer starts at client 0 after reset, grants alternate.
    @(negedge clock);
    set_req(0, 1'b1, 8, 9);
    set_req(1, 1'b1, 20, 15);
    for (int k = 0; k < 9; k++) begin
      @(posedge clock); #1;
      check("arb_c0_ack", 32'(bus.c0_ack), 32'(k == 2 || k == 8));
      check("arb_c1_ack", 32'(bus.c1_ack), 32'(k == 5));
      if (k == 2 || k == 8) check("arb_c0_cell", 32'(bus.c0_cell), 32'(model_read(8, 9)));
      if (k == 5)           check("arb_c1_cell", 32'(bus.c1_cell), 32'(model_read(20, 15)));
    end
    set_req(0, 1'b0, 8, 9);
    set_req(1, 1'b0, 20, 15);
    @(posedge clock); #1;
    check("arb_quiet", 32'(bus.busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
